rib_mem_bridge: RTL

//  Bus responder for the tinyriscv RIB execute-stage master port. It turns single-cycle-level RIB requests

---
 rtl/rib_mem_bridge_pkg.sv | 22 ++
 rtl/rib_mem_bridge_if.sv | 36 +++
 rtl/rib_mem_bridge_timeout.sv | 29 ++
 rtl/rib_mem_bridge.sv | 89 ++++++++
 4 files changed

// File: rtl/rib_mem_bridge_pkg.sv
// Shared constants and types for the RIB-to-Controller memory bridge.
package rib_mem_bridge_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int DEFAULT_ADDR_WIDTH     = 32;
    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    function automatic int timeout_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/rib_mem_bridge_if.sv
// Core-side RIB port and Controller data-memory bus seen by the bridge.
interface rib_mem_bridge_if
    import rib_mem_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  rib_ex_req_i;
    logic                  rib_ex_we_i;
    logic [ADDR_WIDTH-1:0] rib_ex_addr_i;
    logic [DATA_WIDTH-1:0] rib_ex_data_i;
    logic [DATA_WIDTH-1:0] rib_ex_data_o;
    logic                  rib_hold_flag_o;
    logic                  mem_read_o;
    logic                  mem_write_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  mem_ack_i;
    logic                  err_o;

    modport slave (
        input  rib_ex_req_i, rib_ex_we_i, rib_ex_addr_i, rib_ex_data_i,
        input  mem_rdata_i, mem_ack_i,
        output rib_ex_data_o, rib_hold_flag_o,
        output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, err_o
    );

    modport master (
        output rib_ex_req_i, rib_ex_we_i, rib_ex_addr_i, rib_ex_data_i,
        output mem_rdata_i, mem_ack_i,
        input  rib_ex_data_o, rib_hold_flag_o,
        input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, err_o
    );

endinterface

// File: rtl/rib_mem_bridge_timeout.sv
// Saturating watchdog that counts WAIT cycles and flags the last allowed one.
module rib_timeout_counter
    import rib_mem_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST_WAIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // High during the TIMEOUT_CYCLES-th consecutive enabled cycle.
    assign o_expired = i_enable && (r_count == LAST_WAIT);

endmodule

// File: rtl/rib_mem_bridge.sv
// Turns level RIB requests into strobed Controller transactions and stalls the core until acked.
module rib_mem_bridge
    import rib_mem_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    rib_mem_bridge_if.slave  bus
);
    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    op_e                   r_op;
    logic                  r_read;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  w_in_wait;
    logic                  w_ack_live;
    logic                  w_expired;

    assign w_in_wait  = (r_state == ST_WAIT);
    assign w_ack_live = bus.mem_ack_i && ((r_state == ST_ISSUE) || w_in_wait);

    rib_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (!w_in_wait),
        .i_enable  (w_in_wait),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.rib_ex_req_i) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = w_ack_live ? ST_DONE : ST_WAIT;
            ST_WAIT:  if (w_ack_live || w_expired) w_state_next = ST_DONE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_READ;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            if ((r_state == ST_IDLE) && bus.rib_ex_req_i) begin
                r_addr  <= bus.rib_ex_addr_i;
                r_wdata <= bus.rib_ex_data_i;
                r_op    <= op_e'(bus.rib_ex_we_i);
                r_read  <= !bus.rib_ex_we_i;
                r_write <= bus.rib_ex_we_i;
            end
            // An ack on the expiry cycle takes precedence over the timeout.
            if (w_ack_live) begin
                if (r_op == OP_READ) r_rdata <= bus.mem_rdata_i;
            end else if (w_in_wait && w_expired) begin
                r_err <= 1'b1;
                if (r_op == OP_READ) r_rdata <= '0;
            end
        end
    end

    // Qualified by req so a withdrawn request releases the core while the bus access finishes.
    assign bus.rib_hold_flag_o = rst && bus.rib_ex_req_i && (r_state != ST_DONE);
    assign bus.mem_read_o      = r_read;
    assign bus.mem_write_o     = r_write;
    assign bus.mem_addr_o      = r_addr;
    assign bus.mem_wdata_o     = r_wdata;
    assign bus.rib_ex_data_o   = r_rdata;
    assign bus.err_o           = r_err;

endmodule
